// File: rtl/shift_pipe_pkg.sv
// Shared constants for the pipelined barrel shifter: shift/rotate mode codes and a
// constant-foldable clog2 used to size the amount field and the level count.
package shift_pkg;

    localparam logic [1:0] MODE_ROL = 2'b00;
    localparam logic [1:0] MODE_ROR = 2'b01;
    localparam logic [1:0] MODE_SHL = 2'b10;
    localparam logic [1:0] MODE_SHR = 2'b11;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/shift_pipe_if.sv
// Streaming interface for shift_pipe: an input item channel and a result channel,
// each with its own valid/ready pair. The DUT side is the slave modport.
interface shift_pipe_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4,
    parameter int AW    = shift_pkg::clog2(WIDTH)
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] data_in;
    logic [AW-1:0]    amt_in;
    logic [1:0]       mode_in;
    logic [TAG_W-1:0] tag_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] data_out;
    logic [TAG_W-1:0] tag_out;

    modport master (
        output in_valid, data_in, amt_in, mode_in, tag_in, out_ready,
        input  in_ready, out_valid, data_out, tag_out
    );

    modport slave (
        input  in_valid, data_in, amt_in, mode_in, tag_in, out_ready,
        output in_ready, out_valid, data_out, tag_out
    );
endinterface

// File: rtl/shift_pipe_level.sv
// One combinational stage of the shift network: moves data by DIST in the selected mode
// when en is set, otherwise passes it through. Latency 0, no flow control of its own.
module shift_level
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIST  = 1
) (
    input  logic [WIDTH-1:0] data,
    input  logic             en,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] shifted
);

    always_comb begin
        shifted = data;
        if (en) begin
            case (mode)
                MODE_ROL: shifted = {data[WIDTH-DIST-1:0], data[WIDTH-1:WIDTH-DIST]};
                MODE_ROR: shifted = {data[DIST-1:0], data[WIDTH-1:DIST]};
                MODE_SHL: shifted = {data[WIDTH-DIST-1:0], {DIST{1'b0}}};
                default:  shifted = {{DIST{1'b0}}, data[WIDTH-1:DIST]};
            endcase
        end
    end

endmodule

// File: rtl/shift_pipe.sv
// Pipelined barrel shifter/rotator: log2(WIDTH) shift levels with a register slot every LVL_PER_REG levels.
// Latency S = ceil(log2(WIDTH)/LVL_PER_REG) cycles; full throughput while out_ready is high.
// Backpressure: a slot loads when empty or when its successor loads; in_ready is slot 0's load, 0 during flush.
module shift_pipe
    import shift_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int LVL_PER_REG = 1,
    parameter int TAG_W       = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush_in,
    shift_pipe_if.slave io
);

    localparam int N = clog2(WIDTH);
    localparam int S = (N + LVL_PER_REG - 1) / LVL_PER_REG;

    if (WIDTH < 2 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
        $error("shift_pipe: WIDTH must be a power of two >= 2");
    end
    if (LVL_PER_REG < 1 || LVL_PER_REG > N) begin : g_bad_lvl
        $error("shift_pipe: LVL_PER_REG must be in 1..log2(WIDTH)");
    end
    if (TAG_W < 1) begin : g_bad_tag
        $error("shift_pipe: TAG_W must be >= 1");
    end

    logic             vld_q  [S];
    logic             vld_d  [S];
    logic [WIDTH-1:0] dat_q  [S];
    logic [WIDTH-1:0] dat_d  [S];
    logic [N-1:0]     amt_q  [S];
    logic [N-1:0]     amt_d  [S];
    logic [1:0]       mode_q [S];
    logic [1:0]       mode_d [S];
    logic [TAG_W-1:0] tag_q  [S];
    logic [TAG_W-1:0] tag_d  [S];

    // Operands feeding the levels in front of each slot: ports for slot 0, previous slot otherwise.
    logic             src_vld  [S];
    logic [WIDTH-1:0] src_dat  [S];
    logic [N-1:0]     src_amt  [S];
    logic [1:0]       src_mode [S];
    logic [TAG_W-1:0] src_tag  [S];
    logic [WIDTH-1:0] slot_res [S];

    logic [S-1:0] ld;
    logic         in_rdy;

    // A slot may load if any slot at or after it is empty, or the result is being taken.
    always_comb begin
        logic hole;
        ld   = '0;
        hole = io.out_ready;
        for (int i = S - 1; i >= 0; i--) begin
            hole  = hole || !vld_q[i];
            ld[i] = hole;
        end
    end

    assign in_rdy = ld[0] && !flush_in;

    always_comb begin
        src_vld[0]  = io.in_valid;
        src_dat[0]  = io.data_in;
        src_amt[0]  = io.amt_in;
        src_mode[0] = io.mode_in;
        src_tag[0]  = io.tag_in;
        for (int i = 1; i < S; i++) begin
            src_vld[i]  = vld_q[i-1];
            src_dat[i]  = dat_q[i-1];
            src_amt[i]  = amt_q[i-1];
            src_mode[i] = mode_q[i-1];
            src_tag[i]  = tag_q[i-1];
        end
    end

    for (genvar j = 0; j < N; j++) begin : g_lvl
        localparam int SL = j / LVL_PER_REG;
        logic [WIDTH-1:0] lvl_i;
        logic [WIDTH-1:0] lvl_o;
        if (j % LVL_PER_REG == 0) begin : g_head
            assign lvl_i = src_dat[SL];
        end else begin : g_chain
            assign lvl_i = g_lvl[j-1].lvl_o;
        end
        shift_level #(
            .WIDTH (WIDTH),
            .DIST  (1 << j)
        ) u_lvl (
            .data    (lvl_i),
            .en      (src_amt[SL][j]),
            .mode    (src_mode[SL]),
            .shifted (lvl_o)
        );
    end

    for (genvar i = 0; i < S; i++) begin : g_res
        localparam int LAST = (((i + 1) * LVL_PER_REG < N) ? (i + 1) * LVL_PER_REG : N) - 1;
        assign slot_res[i] = g_lvl[LAST].lvl_o;
    end

    // Payload is only captured alongside a valid item so bubbles never disturb held data.
    always_comb begin
        for (int i = 0; i < S; i++) begin
            vld_d[i]  = vld_q[i];
            dat_d[i]  = dat_q[i];
            amt_d[i]  = amt_q[i];
            mode_d[i] = mode_q[i];
            tag_d[i]  = tag_q[i];
            if (flush_in) begin
                vld_d[i] = 1'b0;
            end else if (ld[i]) begin
                vld_d[i] = src_vld[i];
                if (src_vld[i]) begin
                    dat_d[i]  = slot_res[i];
                    amt_d[i]  = src_amt[i];
                    mode_d[i] = src_mode[i];
                    tag_d[i]  = src_tag[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < S; i++) begin
                vld_q[i]  <= 1'b0;
                dat_q[i]  <= '0;
                amt_q[i]  <= '0;
                mode_q[i] <= '0;
                tag_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < S; i++) begin
                vld_q[i]  <= vld_d[i];
                dat_q[i]  <= dat_d[i];
                amt_q[i]  <= amt_d[i];
                mode_q[i] <= mode_d[i];
                tag_q[i]  <= tag_d[i];
            end
        end
    end

    assign io.in_ready  = in_rdy;
    assign io.out_valid = vld_q[S-1];
    assign io.data_out  = dat_q[S-1];
    assign io.tag_out   = tag_q[S-1];

endmodule

// File: tb/tb_shift_pipe.sv
// Bench for shift_pipe: a 32-bit single-level-per-slot pipe plus 8-bit and 64-bit variants,
// checked against an arithmetic shift/rotate model and a queue of in-flight items.
module tb_shift_pipe;
    import shift_pkg::*;

    localparam int S   = 5;   // WIDTH=32, LVL_PER_REG=1
    localparam int S8  = 1;   // WIDTH=8,  LVL_PER_REG=3
    localparam int S64 = 2;   // WIDTH=64, LVL_PER_REG=4

    typedef struct packed {
        logic [63:0] d;
        logic [3:0]  t;
    } exp_t;

    logic clk;
    logic rst_n;
    logic flush_in;
    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t exp_q[$];
    exp_t q8[$];
    exp_t q64[$];

    shift_pipe_if #(.WIDTH(32), .TAG_W(4)) m ();
    shift_pipe_if #(.WIDTH(8),  .TAG_W(4)) if8 ();
    shift_pipe_if #(.WIDTH(64), .TAG_W(4)) if64 ();

    shift_pipe #(.WIDTH(32), .LVL_PER_REG(1), .TAG_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush_in(flush_in), .io(m));
    shift_pipe #(.WIDTH(8), .LVL_PER_REG(3), .TAG_W(4)) dut8 (
        .clk(clk), .rst_n(rst_n), .flush_in(flush_in), .io(if8));
    shift_pipe #(.WIDTH(64), .LVL_PER_REG(4), .TAG_W(4)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush_in(flush_in), .io(if64));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] ref_op(input logic [63:0] d, input int amt,
                                           input logic [1:0] mode, input int w);
        logic [63:0] mask;
        logic [63:0] x;
        logic [63:0] r;
        mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        x = d & mask;
        case (mode)
            2'b00:   r = (x << amt) | (x >> (w - amt));
            2'b01:   r = (x >> amt) | (x << (w - amt));
            2'b10:   r = x << amt;
            default: r = x >> amt;
        endcase
        return r & mask;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_one(input logic [31:0] d, input int amt, input logic [1:0] md,
                            input logic [3:0] tg, input logic [31:0] exp, input string tag);
        int lat;
        @(negedge clk);
        m.out_ready = 1'b1;
        m.in_valid  = 1'b1;
        m.data_in   = d;
        m.amt_in    = amt[4:0];
        m.mode_in   = md;
        m.tag_in    = tg;
        #1 chk({tag, "-in_ready"}, m.in_ready, 1);
        lat = 0;
        do begin
            @(negedge clk);
            m.in_valid = 1'b0;
            lat++;
            #1;
        end while (!m.out_valid && lat < 4 * S + 4);
        chk({tag, "-latency"}, lat, S);
        chk({tag, "-data"}, m.data_out, exp);
        chk({tag, "-tag"}, m.tag_out, tg);
    endtask

    task automatic run_stream(input int n_items, input int rdy_pct, input int in_pct,
                              input string tag, output int cyc);
        int   sent;
        int   got;
        logic prev_stall;
        logic [31:0] prev_dat;
        logic [3:0]  prev_tag;
        exp_t e;
        sent = 0;
        got  = 0;
        cyc  = 0;
        prev_stall = 1'b0;
        prev_dat   = '0;
        prev_tag   = '0;
        exp_q.delete();
        while (got < n_items && cyc < 20 * n_items + 100) begin
            @(negedge clk);
            m.out_ready = ($urandom_range(0, 99) < rdy_pct);
            m.in_valid  = (sent < n_items) && ($urandom_range(0, 99) < in_pct);
            m.data_in   = $urandom;
            m.amt_in    = 5'($urandom_range(0, 31));
            m.mode_in   = 2'($urandom_range(0, 3));
            m.tag_in    = 4'($urandom_range(0, 15));
            #1;
            chk({tag, "-in_ready"}, m.in_ready, (exp_q.size() < S) || m.out_ready);
            if (prev_stall) begin
                chk({tag, "-hold_valid"}, m.out_valid, 1);
                chk({tag, "-hold_data"}, m.data_out, prev_dat);
                chk({tag, "-hold_tag"}, m.tag_out, prev_tag);
            end
            if (m.out_valid && m.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk({tag, "-spurious_out"}, 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk({tag, "-data"}, m.data_out, e.d);
                    chk({tag, "-tag"}, m.tag_out, e.t);
                end
                got++;
            end
            prev_stall = m.out_valid && !m.out_ready;
            prev_dat   = m.data_out;
            prev_tag   = m.tag_out;
            if (m.in_valid && m.in_ready) begin
                e.d = ref_op({32'd0, m.data_in}, int'(m.amt_in), m.mode_in, 32);
                e.t = m.tag_in;
                exp_q.push_back(e);
                sent++;
            end
            cyc++;
        end
        chk({tag, "-all_received"}, got, n_items);
        @(negedge clk);
        m.in_valid  = 1'b0;
        m.out_ready = 1'b1;
    endtask

    initial begin
        int   cyc;
        exp_t e;
        rst_n    = 1'b1;
        flush_in = 1'b0;
        m.in_valid = 1'b0; m.out_ready = 1'b0; m.data_in = '0; m.amt_in = '0; m.mode_in = '0; m.tag_in = '0;
        if8.in_valid = 1'b0; if8.out_ready = 1'b0; if8.data_in = '0; if8.amt_in = '0; if8.mode_in = '0; if8.tag_in = '0;
        if64.in_valid = 1'b0; if64.out_ready = 1'b0; if64.data_in = '0; if64.amt_in = '0; if64.mode_in = '0; if64.tag_in = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("reset-out_valid", m.out_valid, 0);
        chk("reset-data_out", m.data_out, 0);
        chk("reset-tag_out", m.tag_out, 0);
        chk("reset-in_ready", m.in_ready, 1);
        chk("reset-w8_out_valid", if8.out_valid, 0);
        chk("reset-w64_out_valid", if64.out_valid, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed shift/rotate cases
        send_one(32'h80000001, 1,  MODE_ROL, 4'h1, 32'h00000003, "rol1");
        send_one(32'h00000001, 4,  MODE_ROR, 4'h2, 32'h10000000, "ror4");
        send_one(32'hFFFFFFFF, 31, MODE_SHL, 4'h3, 32'h80000000, "shl31");
        send_one(32'h80000000, 31, MODE_SHR, 4'h4, 32'h00000001, "shr31");
        send_one(32'hDEADBEEF, 0,  MODE_ROL, 4'h5, 32'hDEADBEEF, "amt0_rol");
        send_one(32'hDEADBEEF, 0,  MODE_ROR, 4'h6, 32'hDEADBEEF, "amt0_ror");
        send_one(32'hDEADBEEF, 0,  MODE_SHL, 4'h7, 32'hDEADBEEF, "amt0_shl");
        send_one(32'hDEADBEEF, 0,  MODE_SHR, 4'h8, 32'hDEADBEEF, "amt0_shr");
        send_one(32'h12345678, 31, MODE_ROR, 4'h9, 32'h2468ACF0, "ror31");

        // Back-to-back stream: one result per cycle after the pipe fills
        run_stream(64, 100, 100, "b2b", cyc);
        chk("b2b-cycles", cyc, 64 + S);

        // Random backpressure and gaps on the input side
        run_stream(100, 50, 80, "bp", cyc);

        // Flush with three items in flight
        m.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            m.in_valid = 1'b1;
            m.data_in  = $urandom;
            m.amt_in   = 5'($urandom_range(0, 31));
            m.mode_in  = 2'($urandom_range(0, 3));
            m.tag_in   = 4'($urandom_range(0, 15));
        end
        @(negedge clk);
        flush_in  = 1'b1;
        m.data_in = 32'h12345678;
        #1 chk("flush-in_ready", m.in_ready, 0);
        @(negedge clk);
        flush_in    = 1'b0;
        m.in_valid  = 1'b0;
        m.out_ready = 1'b1;
        #1 chk("flush-out_valid", m.out_valid, 0);
        for (int i = 0; i < S + 2; i++) begin
            @(negedge clk);
            #1 chk("flush-stays_empty", m.out_valid, 0);
        end
        send_one(32'h0000F00D, 8, MODE_SHL, 4'hA, 32'h00F00D00, "post_flush");
        @(negedge clk);
        #1 chk("post_flush-alone", m.out_valid, 0);

        // Asynchronous reset while the pipe is full and stalled
        m.out_ready = 1'b0;
        for (int i = 0; i < S + 2; i++) begin
            m.in_valid = 1'b1;
            m.data_in  = $urandom | 32'h1;
            m.amt_in   = 5'd0;
            m.mode_in  = MODE_ROL;
            m.tag_in   = 4'hF;
            @(negedge clk);
        end
        m.in_valid = 1'b0;
        #1;
        chk("pre_reset-out_valid", m.out_valid, 1);
        chk("pre_reset-full", m.in_ready, 0);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_reset-out_valid", m.out_valid, 0);
        chk("mid_reset-data_out", m.data_out, 0);
        chk("mid_reset-tag_out", m.tag_out, 0);
        chk("mid_reset-in_ready", m.in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        m.out_ready = 1'b1;
        for (int i = 0; i < S + 1; i++) begin
            @(negedge clk);
            #1 chk("post_reset-empty", m.out_valid, 0);
        end

        // Width sweep: 8-bit single slot and 64-bit with an uneven last slot
        q8.delete();
        q64.delete();
        if8.out_ready  = 1'b1;
        if64.out_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            chk("w8-out_valid", if8.out_valid, (c >= S8) && (c < 32 + S8));
            if (if8.out_valid && q8.size() > 0) begin
                e = q8.pop_front();
                chk("w8-data", if8.data_out, e.d);
                chk("w8-tag", if8.tag_out, e.t);
            end
            chk("w64-out_valid", if64.out_valid, (c >= S64) && (c < 32 + S64));
            if (if64.out_valid && q64.size() > 0) begin
                e = q64.pop_front();
                chk("w64-data", if64.data_out, e.d);
                chk("w64-tag", if64.tag_out, e.t);
            end
            if (c < 32) begin
                if8.in_valid = 1'b1;
                if8.data_in  = 8'($urandom);
                if8.amt_in   = 3'($urandom_range(0, 7));
                if8.mode_in  = 2'($urandom_range(0, 3));
                if8.tag_in   = 4'($urandom_range(0, 15));
                e.d = ref_op({56'd0, if8.data_in}, int'(if8.amt_in), if8.mode_in, 8);
                e.t = if8.tag_in;
                q8.push_back(e);
                if64.in_valid = 1'b1;
                if64.data_in  = {$urandom, $urandom};
                if64.amt_in   = 6'($urandom_range(0, 63));
                if64.mode_in  = 2'($urandom_range(0, 3));
                if64.tag_in   = 4'($urandom_range(0, 15));
                e.d = ref_op(if64.data_in, int'(if64.amt_in), if64.mode_in, 64);
                e.t = if64.tag_in;
                q64.push_back(e);
                #1;
                chk("w8-in_ready", if8.in_ready, 1);
                chk("w64-in_ready", if64.in_ready, 1);
            end else begin
                if8.in_valid  = 1'b0;
                if64.in_valid = 1'b0;
            end
        end
        chk("w8-drained", q8.size(), 0);
        chk("w64-drained", q64.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
